uart_div_sched: RTL and testbench
=================================

Name: uart_div_sched

Overview:
- Frame sequencer for the UART division service.
- Assembles a 4-byte request (dividend, divisor) from the UART receiver and runs a shared 16-bit sequential divider.
- Returns quotient and remainder as a 4-byte reply through the UART transmitter handshake, and drives the LED quotient display.
- Sits between the uart_rx/uart_tx byte interfaces and the board LEDs.

Parameters:
- BIT_MAX, 16: operand/quotient/remainder width. Fixed at 16; frame byte count assumes 16.
- TIMEOUT_CYC, 5000000: idle clocks between bytes of a partial frame before it is discarded (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_busy  in  1  transmitter busy; goes high no later than the cycle after tx_start
- tx_start  out  1  one-cycle pulse: transmitter loads tx_data
- tx_data  out  8  byte to send; stable from tx_start until tx_busy falls
- y_to_led  out  24  {8'h00, last quotient}
- div0_err  out  1  sticky: last frame had divisor 0; cleared at next frame's first byte
- frame_err  out  1  one-cycle pulse on inter-byte timeout
- rx_overrun  out  1  one-cycle pulse when rx_valid arrives outside RX
- busy  out  1  high in every state except RX

Behaviour:
- Reset (rst=1 at a clk edge): state RX, byte index 0, timeout counter 0, a=b=q=r=0. All outputs 0 (tx_data=0, y_to_led=0). Reset mid-frame, mid-divide or mid-transmit aborts immediately. No further tx_start is issued.
- Request frame: byte order is a[7:0], a[15:8], b[7:0], b[15:8] (little-endian).
- Reply frame: q[7:0], q[15:8], r[7:0], r[15:8].
- RX state:
  - On rx_valid, store the byte at index idx, then idx++.
  - At idx 0, also clear div0_err.
  - The 4th byte moves the state to CHECK on the next cycle.
- Timeout counter: counts while idx!=0 and no rx_valid; resets on every rx_valid. Reaching TIMEOUT_CYC-1 sets idx=0 and pulses frame_err. Stored partial bytes are ignored.
- CHECK (1 cycle):
  - If b==0: q=16'hFFFF, r=a, div0_err=1, go to TX_SEND.
  - Else: pulse div_start to the sub-divider, go to DIV_WAIT.
- DIV_WAIT: on div_done, latch q,r and go to TX_SEND. Divider latency is exactly BIT_MAX+1 clocks from div_start to div_done.
- y_to_led updates in the cycle q is latched.
- TX_SEND:
  - If tx_busy==0: drive tx_data=byte[k], pulse tx_start, go to TX_HOLD.
  - Else stay.
- TX_HOLD: 1 cycle, absorbs transmitter load latency, then go to TX_WAIT.
- TX_WAIT: when tx_busy==0, k++. If k was 3, go to RX with idx=0; else go to TX_SEND.
- rx_valid in any state other than RX: byte dropped, rx_overrun pulses the next cycle.
- Same-cycle rx_valid and timeout expiry: the byte wins, and the counter resets.

Decomposition:
- Shared package uart_div_pkg: state encoding (RX, CHECK, DIV_WAIT, TX_SEND, TX_HOLD, TX_WAIT), FRAME_BYTES=4, default TIMEOUT_CYC.
- One sub-module, seq_div16: restoring divider, 1 bit per clock.
  - Inputs: clk, rst, div_start, a, b.
  - Outputs: div_done (1-cycle pulse), q, r.
  - Only started when b!=0.

Test Plan:
- Normal: rx E8 03 07 00 (1000/7) -> tx 8E 00 06 00, y_to_led=24'h00008E, div0_err=0, first tx_start exactly BIT_MAX+3 cycles after the 4th rx_valid.
- Div by zero: rx 34 12 00 00 -> no div_start, tx FF FF 34 12, div0_err=1 until the next frame's first byte.
- Extremes: FFFF/0001 -> tx FF FF 00 00. 0005/0009 -> tx 00 00 05 00.
- Timeout: rx E8 03, idle TIMEOUT_CYC cycles -> frame_err pulse. Then rx 64 00 0A 00 -> tx 0A 00 00 00.
- Overrun/backpressure:
  - Hold tx_busy high for 50 cycles after each tx_start -> exactly 4 tx_start pulses, tx_data stable while busy.
  - rx_valid during TX -> rx_overrun pulse, reply unchanged.
- Reset mid-transmit: rst after 2nd tx_start -> no further tx_start, outputs 0, next full frame handled correctly.

Source files
------------

// File: rtl/uart_div_pkg.sv
// Shared definitions for the UART division service: frame geometry,
// sequencer state encoding and the reply byte selector.
package uart_div_pkg;

  localparam int BIT_MAX         = 16;
  localparam int FRAME_BYTES     = 4;
  localparam int TIMEOUT_CYC_DEF = 5_000_000;  // 100 ms at 50 MHz

  typedef enum logic [2:0] {
    ST_RX,
    ST_CHECK,
    ST_DIV_WAIT,
    ST_TX_SEND,
    ST_TX_HOLD,
    ST_TX_WAIT
  } state_t;

  // Reply byte order is q low, q high, r low, r high.
  function automatic logic [7:0] reply_byte(input logic [1:0]  k,
                                            input logic [15:0] q,
                                            input logic [15:0] r);
    logic [7:0] b;
    case (k)
      2'd0:    b = q[7:0];
      2'd1:    b = q[15:8];
      2'd2:    b = r[7:0];
      default: b = r[15:8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seq_div16.sv
// Restoring divider, one quotient bit per clock. Loads on div_start and
// pulses div_done BIT_MAX+1 clocks after div_start rises. The caller
// never starts it with b == 0.
module seq_div16
  import uart_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        div_done,
  output logic [15:0] q,
  output logic [15:0] r
);

  logic [15:0] dvs;
  logic [3:0]  cnt;
  logic        run;
  logic [16:0] shifted;
  logic [15:0] rem_sub;
  logic        fits;

  // Trial subtraction: the partial remainder is always below the divisor,
  // so the restored difference fits in 16 bits.
  always_comb begin
    shifted = {r, q[15]};
    fits    = shifted >= {1'b0, dvs};
    rem_sub = shifted[15:0] - dvs;
  end

  // Load operands, then shift/subtract one bit per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvs      <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        q   <= a;
        r   <= '0;
        dvs <= b;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        if (fits) begin
          r <= rem_sub;
          q <= {q[14:0], 1'b1};
        end else begin
          r <= shifted[15:0];
          q <= {q[14:0], 1'b0};
        end
        cnt <= cnt + 4'd1;
        if (cnt == 4'(BIT_MAX - 1)) begin
          run      <= 1'b0;
          div_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_div_sched.sv
// Frame sequencer: collects a 4-byte {a, b} request from the UART
// receiver, divides a by b, and sends {q, r} back through the UART
// transmitter handshake while showing the quotient on the LEDs.
module uart_div_sched
  import uart_div_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [23:0] y_to_led,
  output logic        div0_err,
  output logic        frame_err,
  output logic        rx_overrun,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t        state;
  logic [1:0]    idx;
  logic [1:0]    k;
  logic [TW-1:0] tout;
  logic [15:0]   a;
  logic [15:0]   b;
  logic [15:0]   q;
  logic [15:0]   r;
  logic          div_start;
  logic          div_done;
  logic [15:0]   dq;
  logic [15:0]   dr;

  // Started straight out of CHECK so the divider loads on the same edge
  // that moves the sequencer into DIV_WAIT.
  assign div_start = (state == ST_CHECK) && (b != 16'd0);
  assign busy      = (state != ST_RX);

  seq_div16 u_div (
    .clk       (clk),
    .rst       (rst),
    .div_start (div_start),
    .a         (a),
    .b         (b),
    .div_done  (div_done),
    .q         (dq),
    .r         (dr)
  );

  // Sequencer: receive, divide, transmit; status pulses default low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RX;
      idx        <= '0;
      k          <= '0;
      tout       <= '0;
      a          <= '0;
      b          <= '0;
      q          <= '0;
      r          <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      y_to_led   <= '0;
      div0_err   <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch below sees the
      // pre-edge register values, independent of statement order.
      tx_start   <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
      if (rx_valid && state != ST_RX) rx_overrun <= 1'b1;

      case (state)
        ST_RX: begin
          if (rx_valid) begin
            tout <= '0;
            case (idx)
              2'd0: begin
                a[7:0]   <= rx_data;
                div0_err <= 1'b0;
              end
              2'd1:    a[15:8] <= rx_data;
              2'd2:    b[7:0]  <= rx_data;
              default: b[15:8] <= rx_data;
            endcase
            idx <= idx + 2'd1;
            if (idx == 2'(FRAME_BYTES - 1)) state <= ST_CHECK;
          end else if (idx != 2'd0) begin
            if (tout == TW'(TIMEOUT_CYC - 1)) begin
              idx       <= '0;
              tout      <= '0;
              frame_err <= 1'b1;
            end else begin
              tout <= tout + 1'b1;
            end
          end
        end

        ST_CHECK: begin
          k <= '0;
          if (b == 16'd0) begin
            q        <= 16'hFFFF;
            r        <= a;
            y_to_led <= {8'h00, 16'hFFFF};
            div0_err <= 1'b1;
            state    <= ST_TX_SEND;
          end else begin
            state <= ST_DIV_WAIT;
          end
        end

        ST_DIV_WAIT: begin
          if (div_done) begin
            q        <= dq;
            r        <= dr;
            y_to_led <= {8'h00, dq};
            state    <= ST_TX_SEND;
          end
        end

        ST_TX_SEND: begin
          if (!tx_busy) begin
            tx_data  <= reply_byte(k, q, r);
            tx_start <= 1'b1;
            state    <= ST_TX_HOLD;
          end
        end

        // Gives the transmitter one clock to raise tx_busy.
        ST_TX_HOLD: state <= ST_TX_WAIT;

        ST_TX_WAIT: begin
          if (!tx_busy) begin
            if (k == 2'(FRAME_BYTES - 1)) begin
              k     <= '0;
              idx   <= '0;
              state <= ST_RX;
            end else begin
              k     <= k + 2'd1;
              state <= ST_TX_SEND;
            end
          end
        end

        default: state <= ST_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_div_sched.sv
// Directed bench for uart_div_sched: table of division frames plus
// hand-written timeout, sticky-error, backpressure/overrun and
// mid-transmit reset sequences. A small transmitter model answers
// tx_start with a tx_busy window.
module tb_uart_div_sched;

  localparam int TOUT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [23:0] y_to_led;
  logic        div0_err;
  logic        frame_err;
  logic        rx_overrun;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  // Transmitter model state
  logic [7:0] tx_q[$];
  logic [7:0] held;
  int         tx_starts = 0;
  int         stab_bad  = 0;
  int         busy_len  = 4;
  int         busy_cnt  = 0;

  uart_div_sched #(.TIMEOUT_CYC(TOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .y_to_led   (y_to_led),
    .div0_err   (div0_err),
    .frame_err  (frame_err),
    .rx_overrun (rx_overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: capture each byte, stay busy for busy_len cycles,
  // and flag any tx_data change while busy.
  always @(negedge clk) begin
    if (rst) begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
    end else if (tx_start) begin
      tx_q.push_back(tx_data);
      held      = tx_data;
      tx_starts = tx_starts + 1;
      tx_busy   = 1'b1;
      busy_cnt  = busy_len;
    end else if (tx_busy) begin
      if (tx_data !== held) stab_bad = stab_bad + 1;
      if (busy_cnt <= 1) tx_busy = 1'b0;
      else busy_cnt = busy_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // One full request/reply exchange with checks on the reply.
  task automatic do_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] q, input logic [15:0] r,
                          input logic div0, input int lat_exp, input bit inject);
    int lat;
    int n;
    int st0;
    int sb0;
    tx_q.delete();
    st0 = tx_starts;
    sb0 = stab_bad;
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
    lat = 0;
    while (!tx_start && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat_exp >= 0) check({tag, "_latency"}, lat, lat_exp);
    if (inject) begin
      repeat (3) @(negedge clk);
      send_byte(8'h55);
      check({tag, "_overrun_pulse"}, {31'd0, rx_overrun}, 32'd1);
      @(negedge clk);
      check({tag, "_overrun_clear"}, {31'd0, rx_overrun}, 32'd0);
    end
    n = 0;
    while (!(tx_q.size() >= 4 && !busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, n < 5000}, 32'd1);
    check({tag, "_tx_count"}, tx_starts - st0, 4);
    if (tx_q.size() >= 4)
      check({tag, "_reply"}, {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, {r[15:8], r[7:0], q[15:8], q[7:0]});
    else
      check({tag, "_reply_len"}, tx_q.size(), 4);
    check({tag, "_led"}, {8'h00, y_to_led}, {16'h0000, q});
    check({tag, "_div0"}, {31'd0, div0_err}, {31'd0, div0});
    check({tag, "_tx_stable"}, stab_bad - sb0, 0);
  endtask

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        div0;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int st0;
    vecs[0] = '{"d1000_7",   16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0, 19};
    vecs[1] = '{"dFFFF_1",   16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 19};
    vecs[2] = '{"d5_9",      16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 19};
    vecs[3] = '{"dFFFF_FFFF",16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 19};
    vecs[4] = '{"dABCD_100", 16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0, 19};
    vecs[5] = '{"d0_5",      16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 19};
    vecs[6] = '{"d1234_0",   16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 2};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_led", {8'd0, y_to_led}, 32'd0);
    check("rst_flags", {28'd0, div0_err, frame_err, rx_overrun, busy}, 32'd0);

    for (int i = 0; i < 7; i++)
      do_frame(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
               vecs[i].div0, vecs[i].lat, 1'b0);

    // div0_err holds until the next frame's first byte; then that partial
    // frame times out and the following full frame is decoded fresh.
    repeat (20) @(negedge clk);
    check("div0_sticky", {31'd0, div0_err}, 32'd1);
    send_byte(8'hE8);
    check("div0_cleared", {31'd0, div0_err}, 32'd0);
    send_byte(8'h03);
    n = 0;
    while (!frame_err && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TOUT);
    @(negedge clk);
    check("frame_err_pulse", {31'd0, frame_err}, 32'd0);
    do_frame("after_timeout", 16'h0064, 16'h000A, 16'h000A, 16'h0000, 1'b0, 19, 1'b0);

    // Backpressure with a byte arriving mid-transmit.
    busy_len = 50;
    do_frame("backpressure", 16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0, 19, 1'b1);
    busy_len = 4;

    // Reset after the second tx_start.
    st0 = tx_starts;
    send_byte(8'h10);
    send_byte(8'h27);
    send_byte(8'h03);
    send_byte(8'h00);
    n = 0;
    while (tx_starts < st0 + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_tx_reached", {31'd0, n < 500}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    check("midrst_led", {8'd0, y_to_led}, 32'd0);
    check("midrst_flags", {27'd0, tx_start, div0_err, frame_err, rx_overrun, busy}, 32'd0);
    repeat (150) @(negedge clk);
    check("midrst_no_more_tx", tx_starts - st0, 2);
    do_frame("post_reset", 16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0, 19, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
